uart_tx_controller: RTL and testbench
=====================================

Name: uart_tx_controller

Overview:
- UART transmit sequencer: accepts bytes over a valid/ready handshake and serialises them as 8N1 frames (start bit, DATA_BITS data bits LSB first, one stop bit).
- Contains its own bit-period counter, equivalent to a baud generator, with a runtime-programmable divisor.
- Sits between the host/bus logic and the TX pin.
- The divisor register is the single point of baud configuration for the transmit path.

Parameters:
- CLK_DIV, 5208, reset value of the divisor in clocks per bit (50 MHz / 9600).
- DIV_WIDTH, 16, width of the divisor register and the bit-period counter.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- div_wr  input  1  divisor write strobe.
- div_in  input  DIV_WIDTH  new divisor in clocks per bit.
- tx_data  input  DATA_BITS  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  controller can accept a byte; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress; equals ~tx_ready.
- bit_tick  output  1  one-cycle pulse on the last clock of every bit period; low in IDLE.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, tx=1, divisor=CLK_DIV, counter=0, bit index=0, shift register=0.
  - After the reset edge: tx_ready=1, busy=0, bit_tick=0.
  - Reset mid-frame aborts the frame; tx=1 from the next cycle.
- Divisor register:
  - Loads div_in on a div_wr edge only when state=IDLE.
  - Writes while busy are ignored.
  - Writes with div_in<2 are ignored; the register keeps its old value.
  - If div_wr and a tx_valid handshake occur in the same IDLE cycle, the new divisor applies to that frame.
- Bit-period counter:
  - Width DIV_WIDTH; counts 0..divisor-1.
  - bit_tick=1 when counter==divisor-1 and state!=IDLE; the counter wraps to 0 on that edge.
  - Counter is held at 0 in IDLE.
- Handshake:
  - Transfer occurs on a posedge with tx_valid&tx_ready.
  - tx_data is latched into the shift register on that edge.
  - tx_valid without tx_ready has no effect; data need not be held.
- States:
  - IDLE: tx=1, tx_ready=1. On handshake -> START.
  - START: tx=0 for exactly divisor cycles. On bit_tick -> DATA, bit index=0.
  - DATA: tx=shift[0]. On bit_tick: shift right; if bit index==DATA_BITS-1 -> STOP, else increment bit index.
  - STOP: tx=1 for divisor cycles. On bit_tick -> IDLE.
- Latency and timing:
  - tx falls in the first cycle after the accept edge.
  - Frame length is exactly (DATA_BITS+2)*divisor cycles from the first start-bit cycle to the first IDLE cycle.
  - tx_ready rises in the cycle after the final STOP bit_tick.
- Back-to-back frames:
  - A byte accepted in the first IDLE cycle starts its start bit the next cycle.
  - This gives exactly 1 idle-high cycle between frames, beyond the full stop bit.
- tx is registered: no glitches, no combinational path from inputs to tx.

Test Plan:
- Reset state: hold rst 3 cycles, release -> tx=1, tx_ready=1, busy=0, bit_tick=0. Then 20 idle cycles -> tx stays 1.
- Divisor write and single frame: div_wr with div_in=4 in IDLE, then send 0xA5 -> tx sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1. tx_ready low for exactly 40 cycles. bit_tick pulses 10 times, 4 cycles apart.
- Back-to-back: divisor 4, tx_valid held high with 0x00 then 0xFF -> second start bit begins exactly 1 cycle after the first frame ends. Line decodes 0x00 then 0xFF.
- Divisor write ignored: div_wr div_in=8 mid-frame -> current and next frame still use 4. div_wr div_in=1 in IDLE -> divisor stays 4. div_wr div_in=6 in IDLE -> next frame uses 6-cycle bits (60-cycle frame).
- Reset mid-frame: assert rst during DATA bit 3 of 0x3C -> tx=1 next cycle, tx_ready=1, divisor=CLK_DIV. A new byte at divisor 5208 produces 5208-cycle bits.
- Handshake hygiene: tx_valid pulsed while busy -> no extra frame, tx_data change mid-frame does not corrupt the line. Simultaneous div_wr (div_in=3) and handshake in IDLE -> frame uses 3-cycle bits.

Source files
------------

// File: rtl/uart_tx_controller.sv
// UART 8N1 transmitter: valid/ready byte input, serial tx out, runtime baud divisor.
// Latency: tx falls the cycle after the accept edge; each frame lasts (DATA_BITS+2)*divisor cycles.
// Backpressure: tx_ready is high only in IDLE, so one byte is accepted per frame.
module uart_tx_controller #(
    parameter int CLK_DIV   = 5208,
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_wr,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 bit_tick
);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 tx_n;
    logic                 tick;

    assign tick     = (state != IDLE) && (cnt == divisor - DIV_WIDTH'(1));
    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;
    assign bit_tick = tick;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        idx_n   = idx;
        shift_n = shift;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n = START;
                    shift_n = tx_data;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state != IDLE && !tick) begin
            cnt_n = cnt + DIV_WIDTH'(1);
        end

        // tx is registered from the next state so the line changes exactly on state boundaries
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            divisor <= DIV_WIDTH'(CLK_DIV);
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
        end else begin
            state <= state_n;
            tx    <= tx_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            if (state == IDLE && div_wr && div_in >= DIV_WIDTH'(2)) begin
                divisor <= div_in;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// Randomised self-checking bench for uart_tx_controller; expected line levels come from frame-level bit rules.
module tb_uart_tx_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        div_wr;
    logic [15:0] div_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        busy;
    logic        bit_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_controller #(.CLK_DIV(5208), .DIV_WIDTH(16), .DATA_BITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy),
        .bit_tick (bit_tick)
    );

    // Frame bit n of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic frame_bit(input logic [7:0] d, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return d[n-1];
        return 1'b1;
    endfunction

    // Line must sit idle-high with the controller ready for n cycles
    task automatic idle_check(input string name, input int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || bit_tick !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s: %0d non-idle cycles seen, required 0", name, bad);
        end
    endtask

    // Called at a negedge in IDLE; leaves us at the negedge of the first start-bit cycle
    task automatic start_frame(input logic [7:0] d, input logic wr, input logic [15:0] wv);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: tx_ready=%b required 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = d;
        div_wr   = wr;
        div_in   = wv;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        div_wr   = 1'b0;
    endtask

    // Checks a whole frame cycle by cycle; act 1 = divisor write of 8, act 2 = tx_valid pulse with altered data
    task automatic run_frame(input string name, input logic [7:0] d, input int div, input int act, input int act_at);
        int bad_tx = 0, bad_rdy = 0, bad_tick = 0, ticks = 0, first = -1;
        for (int k = 0; k < 10 * div; k++) begin
            logic e;
            e = frame_bit(d, k / div);
            if (tx !== e) begin
                bad_tx++;
                if (first < 0) first = k;
            end
            if (tx_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
            if (bit_tick !== ((k % div) == (div - 1))) bad_tick++;
            if (bit_tick === 1'b1) ticks++;
            if (k == act_at) begin
                if (act == 1) begin div_wr = 1'b1; div_in = 16'd8; end
                if (act == 2) begin tx_valid = 1'b1; tx_data = ~d; end
            end else if (k == act_at + 1) begin
                div_wr   = 1'b0;
                tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (bad_tx !== 0) begin
            errors++;
            $display("FAIL %s_tx: %0d wrong line cycles (first at %0d) for byte %h div %0d, required 0", name, bad_tx, first, d, div);
        end
        checks++;
        if (bad_rdy !== 0) begin
            errors++;
            $display("FAIL %s_busy: tx_ready/busy wrong in %0d of %0d frame cycles, required 0", name, bad_rdy, 10 * div);
        end
        checks++;
        if (bad_tick !== 0 || ticks !== 10) begin
            errors++;
            $display("FAIL %s_tick: %0d ticks with %0d misplaced, required 10 ticks every %0d cycles", name, ticks, bad_tick, div);
        end
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1 || bit_tick !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: ready=%b busy=%b tx=%b tick=%b required 1 0 1 0", name, tx_ready, busy, tx, bit_tick);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || bit_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b ready=%b busy=%b tick=%b required 1 1 0 0", tx, tx_ready, busy, bit_tick);
        end
        idle_check("reset_idle", 20);
    endtask

    task automatic test_single_frame();
        div_wr = 1'b1;
        div_in = 16'd4;
        @(posedge clk);
        @(negedge clk);
        div_wr = 1'b0;
        start_frame(8'hA5, 1'b0, 16'd0);
        run_frame("single_a5", 8'hA5, 4, 0, -5);
        idle_check("single_after", 5);
    endtask

    task automatic test_back_to_back();
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        run_frame("b2b_first", 8'h00, 4, 0, -5);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame("b2b_second", 8'hFF, 4, 0, -5);
        idle_check("b2b_after", 3);
    endtask

    task automatic test_div_ignored();
        logic [7:0] b;
        b = 8'($urandom);
        start_frame(b, 1'b0, 16'd0);
        run_frame("div_busy_cur", b, 4, 1, 10);
        idle_check("div_busy_gap", 2);
        b = 8'($urandom);
        start_frame(b, 1'b0, 16'd0);
        run_frame("div_busy_next", b, 4, 0, -5);
        div_wr = 1'b1;
        div_in = 16'd1;
        @(posedge clk);
        @(negedge clk);
        div_wr = 1'b0;
        b = 8'($urandom);
        start_frame(b, 1'b0, 16'd0);
        run_frame("div_small", b, 4, 0, -5);
        div_wr = 1'b1;
        div_in = 16'd6;
        @(posedge clk);
        @(negedge clk);
        div_wr = 1'b0;
        b = 8'($urandom);
        start_frame(b, 1'b0, 16'd0);
        run_frame("div_six", b, 6, 0, -5);
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            int         dv;
            b  = 8'($urandom);
            dv = int'($urandom_range(2, 7));
            idle_check("rand_gap", int'($urandom_range(1, 4)));
            start_frame(b, 1'b1, 16'(dv));
            run_frame("rand", b, dv, 0, -5);
        end
    endtask

    task automatic test_handshake_hygiene();
        logic [7:0] b;
        div_wr = 1'b1;
        div_in = 16'd4;
        @(posedge clk);
        @(negedge clk);
        div_wr = 1'b0;
        b = 8'($urandom);
        start_frame(b, 1'b0, 16'd0);
        run_frame("hyg_pulse", b, 4, 2, 13);
        idle_check("hyg_no_extra", 12);
        b = 8'($urandom);
        start_frame(b, 1'b1, 16'd3);
        run_frame("hyg_simul_div", b, 3, 0, -5);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        div_wr = 1'b1;
        div_in = 16'd4;
        @(posedge clk);
        @(negedge clk);
        div_wr = 1'b0;
        start_frame(8'h3C, 1'b0, 16'd0);
        repeat (17) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit3: tx=%b busy=%b required 1 1", tx, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || bit_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b ready=%b busy=%b tick=%b required 1 1 0 0", tx, tx_ready, busy, bit_tick);
        end
        b = 8'($urandom);
        start_frame(b, 1'b0, 16'd0);
        run_frame("mid_default_div", b, 5208, 0, -5);
    endtask

    initial begin
        rst      = 1'b1;
        div_wr   = 1'b0;
        div_in   = '0;
        tx_data  = '0;
        tx_valid = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_ignored();
        test_random_frames();
        test_handshake_hygiene();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
